ram_bus_bridge: RTL
===================

// Module: ram_bus_bridge
// PURPOSE
//  Upstream front-end for RAM_SinglePort. Accepts burst requests from a cache/bus master and sequences them into
//  per-beat RAM enables, addresses and strobes. Returns read data after the RAM's fixed READ_LATENCY and
//  acknowledges write beats. Sits between the cache bus and the single-port RAM in the memory subsystem.
// PARAMETERS
//  ADDR_WIDTH    10  RAM word-address width; must equal the RAM's ADDR_WIDTH
//  DATA_WIDTH    64  beat/word width in bits, multiple of 8; RAM byte lanes are 8 bits (STRB_W = DATA_WIDTH/8)
//  READ_LATENCY  1   RAM read latency in cycles, 0..4; must equal the RAM's READ_LATENCY
//  LEN_WIDTH     4   burst length field width; a burst is len+1 beats, max 16
// PORTS
//  clk        in   1           clock
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   1           request pending; master holds it and all req_* fields stable until the last beat
//  req_write  in   1           1 = write burst, 0 = read burst
//  req_addr   in   64          byte address of the first beat; low log2(STRB_W) bits ignored
//  req_len    in   LEN_WIDTH   number of beats minus 1
//  req_strobe in   STRB_W      byte enables for the current write beat
//  req_data   in   DATA_WIDTH  current write beat; master advances it after each resp_ready
//  resp_ready out  1           read: resp_data valid this cycle; write: current beat accepted this cycle
//  resp_last  out  1           qualifies the final beat; only high together with resp_ready
//  resp_data  out  DATA_WIDTH  read data; '0 when resp_ready=0
//  ram_en     out  1           RAM enable
//  ram_addr   out  ADDR_WIDTH  RAM word address
//  ram_strobe out  STRB_W      RAM byte write strobes; '0 on reads
//  ram_wdata  out  DATA_WIDTH  RAM write data
//  ram_rdata  in   DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after the address cycle
// BEHAVIOUR
//  - Reset: state=IDLE, all counters and pipeline valids cleared. All outputs 0 while in IDLE.
//  - Word address = req_addr[OFF+ADDR_WIDTH-1:OFF], where OFF = log2(STRB_W); higher bits ignored.
//  - Beat i uses (base+i) mod 2**ADDR_WIDTH; the address wraps silently at the top of the RAM.
//  - IDLE: when req_valid=1, latch addr, len and write; go to WRITE or READ. No response in the accept cycle.
//  - WRITE: one beat per cycle.
//      ram_en=1, ram_strobe=req_strobe, ram_wdata=req_data, ram_addr=base+cnt.
//      resp_ready=1 in the same cycle; resp_last=1 when cnt==len. After the last beat, go to IDLE.
//  - READ: issue phase. ram_en=1, ram_strobe='0, ram_addr=base+icnt, one address per cycle until len+1 issued.
//      - A valid bit per issued beat travels a READ_LATENCY-deep shift register (rd_tracker).
//      - When it emerges: resp_ready=1, resp_data=ram_rdata, rcnt++; resp_last when rcnt==len.
//      - READ_LATENCY=0: data is returned in the issue cycle.
//      - State stays READ until the last beat returns, then IDLE; ram_en=0 once all beats are issued.
//  - Full-rate throughput: a burst of N beats takes N cycles (write) or N+READ_LATENCY cycles (read) after accept.
//  - Master must drop req_valid, or present a new request, in the cycle after resp_last.
//      Bridge samples req_valid again only in IDLE, so there is a 1-cycle gap between bursts.
//  - req_len=0: single beat; resp_ready and resp_last assert together.
//  - req_valid dropping mid-burst is a protocol violation; the bridge ignores it and completes the burst.
//  - Reset mid-burst: next cycle is IDLE, in-flight read valids are discarded, no resp_* pulse is produced.
//      A partial write stays in RAM.
//  - Counters are LEN_WIDTH+1 bits so len=2**LEN_WIDTH-1 never overflows.
// STRUCTURE
//  - Package ram_bridge_pkg holds:
//      state_t enum {IDLE, READ, WRITE}
//      len_t = logic [LEN_WIDTH-1:0]
//      cnt_t = logic [LEN_WIDTH:0]
//  - Sub-module ram_rd_tracker (READ_LATENCY, shift of valid+last bits, sync clear) isolates the latency pipeline.
//  - Top level holds the FSM and the address/count registers.
// TESTING  (DATA_WIDTH=64, ADDR_WIDTH=10, READ_LATENCY=1 unless noted)
//  1. Write, len=3, addr=0x40, strobe=FF, data 11..44:
//     ram_addr 8,9,10,11 on 4 consecutive cycles, resp_ready 4 cycles, resp_last on the 4th, IDLE after.
//  2. Read back addr=0x40, len=3:
//     ram_addr 8..11 issued back to back; resp_data 11,22,33,44 starting 1 cycle later; last on 44.
//  3. Write, len=1, addr=0x1FF8 (word 1023):
//     beats land at words 1023 then 0 (wrap); reading back word 0 returns beat 2.
//  4. Partial strobe 0x0F on word 5 holding 0xAAAA..AA, data 0x5555..55:
//     readback 0xAAAAAAAA_55555555.
//  5. READ_LATENCY=0 and 3, len=15:
//     16 resp_ready pulses, resp_last only on the 16th; first data at latency 0 and 3 respectively.
//  6. Reset asserted in the 2nd read beat:
//     no further resp_ready; ram_en=0 next cycle; a new req is accepted normally 1 cycle after reset drops.

Source files
------------

// File: rtl/ram_bridge_pkg.sv
// Shared types for the cache-bus to single-port RAM bridge.
package ram_bridge_pkg;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef logic [LEN_W_DEF-1:0] len_t;
  typedef logic [LEN_W_DEF:0]   cnt_t;
endpackage

// File: rtl/ram_rd_tracker.sv
// Latency-matching pipeline: carries a valid/last pair per issued read beat
// so the response lines up with the RAM's fixed read latency.
module ram_rd_tracker #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);
  if (LATENCY == 0) begin : g_pass
    logic unused_s;
    assign unused_s = clk ^ clr_i;
    assign valid_o  = valid_i;
    assign last_o   = last_i;
  end else begin : g_pipe
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] last_q;

    always_ff @(posedge clk) begin
      if (clr_i) begin
        valid_q <= '0;
        last_q  <= '0;
      end else begin
        valid_q <= (valid_q << 1) | LATENCY'(valid_i);
        last_q  <= (last_q << 1) | LATENCY'(last_i & valid_i);
      end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign last_o  = last_q[LATENCY-1];
  end
endmodule

// File: rtl/ram_bus_bridge.sv
// Sequences cache-bus bursts into per-beat single-port RAM accesses and
// returns read data / write acknowledges one beat per cycle.
module ram_bus_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [63:0]             req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    resp_ready,
  output logic                    resp_last,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    ram_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_strobe,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);

  typedef logic [LEN_WIDTH:0] cnt_w_t;
  localparam cnt_w_t CNT_ONE = cnt_w_t'(1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  cnt_w_t                 cnt_q, cnt_d;
  cnt_w_t                 rcnt_q, rcnt_d;
  cnt_w_t                 len_ext_s;
  logic                   issue_s;
  logic                   trk_valid_s;
  logic                   trk_last_s;
  logic                   unused_s;

  assign len_ext_s = {1'b0, len_q};
  // cnt_q doubles as the issue counter in READ; it stops once len+1 addresses are out.
  assign issue_s   = (state_q == READ) && (cnt_q <= len_ext_s);
  assign unused_s  = ^{req_addr[63:OFF+ADDR_WIDTH], req_addr[OFF-1:0]};

  ram_rd_tracker #(
    .LATENCY (READ_LATENCY)
  ) u_rd_tracker (
    .clk     (clk),
    .clr_i   (reset),
    .valid_i (issue_s),
    .last_i  (cnt_q == len_ext_s),
    .valid_o (trk_valid_s),
    .last_o  (trk_last_s)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        rcnt_d = '0;
        if (req_valid) begin
          base_d  = req_addr[OFF+ADDR_WIDTH-1:OFF];
          len_d   = req_len;
          state_d = req_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == len_ext_s) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (issue_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (trk_valid_s) begin
          rcnt_d  = rcnt_q + CNT_ONE;
          state_d = (rcnt_q == len_ext_s) ? IDLE : READ;
        end else begin
          rcnt_d  = rcnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Beat-level outputs are decoded from registered state so each beat lands in its own cycle.
  always_comb begin
    ram_en     = (state_q == WRITE) || issue_s;
    ram_addr   = ram_en ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
    ram_strobe = (state_q == WRITE) ? req_strobe : '0;
    ram_wdata  = (state_q == WRITE) ? req_data : '0;
    resp_ready = (state_q == WRITE) || ((state_q == READ) && trk_valid_s);
    resp_last  = ((state_q == WRITE) && (cnt_q == len_ext_s)) ||
                 ((state_q == READ) && trk_valid_s && trk_last_s);
    resp_data  = ((state_q == READ) && trk_valid_s) ? ram_rdata : '0;
  end
endmodule
